reg_file: RTL and testbench
===========================

# reg_file

Parametrised multi-entry register file: the successor to the single 1-bit and 16-bit load registers in the memory directory. It provides one synchronous write port, two combinational read ports with optional write-to-read bypass, and an optional hardwired-zero entry 0. A multi-cycle sweep clears every entry on request without asserting reset. It is the CPU's general-purpose register bank, sitting between the decode/ALU datapath and the write-back path.

## Interface
- WIDTH, 16, data width of each entry (≥1)
- DEPTH, 8, number of entries (≥2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- BYPASS, 1, when 1, a same-cycle write to a read address is forwarded to that read port
- ZERO_REG, 0, when 1, entry 0 always reads 0 and ignores writes

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all entries and control state
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- raddr_a  in  ADDR_W  read port A address
- rdata_a  out  WIDTH  read port A data (combinational)
- raddr_b  in  ADDR_W  read port B address
- rdata_b  out  WIDTH  read port B data (combinational)
- clr  in  1  clear-sweep request, sampled each edge
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep completes

## Operation
- Reset (asynchronous): all entries 0, state IDLE, sweep pointer 0, busy=0, done=0.
- Write: in IDLE with we=1, clr=0 and waddr<DEPTH, the entry takes wdata at the rising edge.
  - Ignored when waddr≥DEPTH.
  - Ignored when ZERO_REG=1 and waddr=0.
- Read: rdata_x = entry[raddr_x].
  - Returns 0 when raddr_x≥DEPTH.
  - Returns 0 when ZERO_REG=1 and raddr_x=0.
  - With BYPASS=1, if the write above is accepted this cycle and waddr=raddr_x, rdata_x=wdata.
  - Ports A and B are independent; both may address the same entry.
- FSM states: IDLE, CLEAR.
  - IDLE → CLEAR when clr=1: pointer←0, busy←1. If we=1 in the same cycle, the write is dropped; clear has priority.
  - In CLEAR, each edge: entry[pointer]←0, pointer←pointer+1.
  - At the edge that clears entry DEPTH-1: → IDLE, busy←0, done←1.
  - done returns to 0 at the next edge.
- While busy: we is ignored (no write, no bypass); clr is ignored. Reads return the current contents: entries already cleared read 0, the rest read their old values.
- Arithmetic: the pointer is ADDR_W bits and never wraps past DEPTH-1.

## Timing
- Write latency: data is visible on the read ports in the cycle after the edge (same cycle if BYPASS=1).
- Sweep: if clr is sampled at edge N, busy=1 from N through N+DEPTH; entry k clears at edge N+1+k. busy falls and done rises at edge N+DEPTH; done falls at N+DEPTH+1.
- A new clr in the cycle where done=1 is accepted; busy is high again after the next edge.
- Reset mid-sweep: immediate return to IDLE with all entries 0, busy=0, done=0 and no done pulse.
- Read paths are purely combinational from address/write inputs to rdata; there are no other combinational input-to-output paths. busy and done are registered.

## Structure
- The shared CPU package holds the state enum (RF_IDLE, RF_CLEAR) and the default WIDTH/DEPTH constants, so the decode and top level use the same values.
- Storage is a WIDTH×DEPTH array in the top module.
- Sub-module reg_file_sweep holds the FSM, the pointer, busy and done. It outputs a clear-enable and a clear address to the array.

## Test plan
- Reset, then write 0xBEEF to entry 3 and read it on A and B: both ports read 0x0000 before the edge. With BYPASS=1 they read 0xBEEF in the write cycle; with BYPASS=0 they read 0xBEEF the next cycle.
- ZERO_REG=1: write 0x1234 to entry 0 → reads 0x0000. Write 0x1234 to entry 1 → reads 0x1234.
- Fill entries 0–7 with 0x1111·(k+1), assert clr one cycle:
  - busy is high for exactly 8 cycles.
  - Entry k reads 0 from the cycle after edge N+1+k; uncleared entries keep their values.
  - done is a single pulse; a we pulse during busy changes nothing.
- Assert clr and we (waddr=2, wdata=0xAAAA) together: the write is dropped, entry 2 reads 0 after the sweep, and the second clr during busy has no effect.
- Assert reset at sweep cycle 3: busy=0 and done=0 immediately, all entries 0, no done pulse afterward.
- DEPTH=6: a write to address 7 is ignored; reads of addresses 6 and 7 return 0; the sweep lasts 6 cycles.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared CPU register-bank definitions: sweep FSM states and default geometry.
package reg_file_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int unsigned RF_WIDTH = 16;
    localparam int unsigned RF_DEPTH = 8;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bus: one write port, two read ports, clear-sweep control.
interface reg_file_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [WIDTH-1:0]  rdata_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_b;
    logic              clr;
    logic              busy;
    logic              done;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, clr,
        input  rdata_a, rdata_b, busy, done
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, clr,
        output rdata_a, rdata_b, busy, done
    );
endinterface

// File: rtl/reg_file_sweep.sv
// Clear-sweep controller: walks a pointer over every entry, then pulses done.
module reg_file_sweep
    import reg_file_pkg::*;
#(
    parameter int unsigned DEPTH  = RF_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output logic              busy,
    output logic              done,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RF_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RF_IDLE: begin
                    if (clr) begin
                        state_q <= RF_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    // Pointer stops at the last entry; it never walks past DEPTH-1.
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= RF_IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                default: state_q <= RF_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign clr_en   = (state_q == RF_CLEAR);
    assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_file.sv
// General-purpose register bank: 1 write port, 2 combinational read ports,
// optional write-to-read bypass, optional hardwired-zero entry 0, clear sweep.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH    = RF_WIDTH,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic     clk,
    input  logic     reset,
    reg_file_if.slave bus
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              busy;
    logic              done;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic [WIDTH-1:0]  rdata_a;
    logic [WIDTH-1:0]  rdata_b;

    reg_file_sweep #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk      (clk),
        .reset    (reset),
        .clr      (bus.clr),
        .busy     (busy),
        .done     (done),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // A clear request wins over a same-cycle write; writes are locked out while sweeping.
    assign wr_ok = bus.we && !bus.clr && !busy && (32'(bus.waddr) < DEPTH) &&
                   !(ZERO_REG && (bus.waddr == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_en) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem_q[bus.waddr] <= bus.wdata;
        end
    end

    always_comb begin
        rdata_a = '0;
        if (BYPASS && wr_ok && (bus.waddr == bus.raddr_a)) begin
            rdata_a = bus.wdata;
        end else if ((32'(bus.raddr_a) < DEPTH) && !(ZERO_REG && (bus.raddr_a == '0))) begin
            rdata_a = mem_q[bus.raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (BYPASS && wr_ok && (bus.waddr == bus.raddr_b)) begin
            rdata_b = bus.wdata;
        end else if ((32'(bus.raddr_b) < DEPTH) && !(ZERO_REG && (bus.raddr_b == '0))) begin
            rdata_b = mem_q[bus.raddr_b];
        end
    end

    assign bus.rdata_a = rdata_a;
    assign bus.rdata_b = rdata_b;
    assign bus.busy    = busy;
    assign bus.done    = done;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: four configurations driven in lockstep, checked every cycle
// against a cycle-count based model plus directed literal expectations.
module tb_reg_file;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        we = 1'b0;
    logic [2:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [2:0]  raddr_a = '0;
    logic [2:0]  raddr_b = '0;
    logic        clr = 1'b0;

    logic [15:0] rd_a [4];
    logic [15:0] rd_b [4];
    logic        busy_o [4];
    logic        done_o [4];

    // u0: bypass, u1: no bypass, u2: zero reg, u3: DEPTH=6
    reg_file_if #(.WIDTH(16), .ADDR_W(3)) bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        reg_file #(
            .WIDTH    (16),
            .DEPTH    ((g == 3) ? 6 : 8),
            .BYPASS   (g != 1),
            .ZERO_REG (g == 2)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus[g])
        );
        assign bus[g].we      = we;
        assign bus[g].waddr   = waddr;
        assign bus[g].wdata   = wdata;
        assign bus[g].raddr_a = raddr_a;
        assign bus[g].raddr_b = raddr_b;
        assign bus[g].clr     = clr;
        assign rd_a[g]   = bus[g].rdata_a;
        assign rd_b[g]   = bus[g].rdata_b;
        assign busy_o[g] = bus[g].busy;
        assign done_o[g] = bus[g].done;
    end

    // Model: contents plus the edge number at which each sweep was accepted.
    int          dep [4] = '{8, 8, 8, 6};
    bit          byp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit          zr  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] mem [4][8];
    int          start [4];
    int          cyc = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            start[i] = -1;
            for (int k = 0; k < 8; k++) mem[i][k] = '0;
        end
    endtask

    function automatic bit m_busy(int i);
        return start[i] >= 0 && cyc >= start[i] && cyc < start[i] + dep[i];
    endfunction

    function automatic bit m_done(int i);
        return start[i] >= 0 && cyc == start[i] + dep[i];
    endfunction

    function automatic bit m_wr(int i);
        return we && !clr && !m_busy(i) && int'(waddr) < dep[i] && !(zr[i] && waddr == 0);
    endfunction

    function automatic logic [15:0] m_rd(int i, logic [2:0] a);
        if (byp[i] && m_wr(i) && waddr == a) return wdata;
        if (int'(a) >= dep[i] || (zr[i] && a == 0)) return 16'h0000;
        return mem[i][a];
    endfunction

    initial begin
        bit wr [4];
        bit ca [4];
        m_reset();
        forever begin
            @(negedge clk);
            if (reset) m_reset();
            for (int i = 0; i < 4; i++) begin
                check($sformatf("u%0d rdata_a", i), rd_a[i], m_rd(i, raddr_a));
                check($sformatf("u%0d rdata_b", i), rd_b[i], m_rd(i, raddr_b));
                check($sformatf("u%0d busy", i), 16'(busy_o[i]), 16'(m_busy(i)));
                check($sformatf("u%0d done", i), 16'(done_o[i]), 16'(m_done(i)));
            end
            @(posedge clk);
            if (reset) begin
                cyc++;
                m_reset();
            end else begin
                for (int i = 0; i < 4; i++) begin
                    wr[i] = m_wr(i);
                    ca[i] = clr && !m_busy(i);
                end
                cyc++;
                for (int i = 0; i < 4; i++) begin
                    if (wr[i]) mem[i][waddr] = wdata;
                    if (start[i] >= 0 && cyc >= start[i] + 1 && cyc <= start[i] + dep[i])
                        mem[i][cyc - start[i] - 1] = '0;
                    if (ca[i]) start[i] = cyc;
                end
            end
        end
    end

    task automatic step(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] a, input logic [2:0] b, input logic c);
        @(posedge clk);
        #1;
        we = w; waddr = wa; wdata = wd; raddr_a = a; raddr_b = b; clr = c;
    endtask

    initial begin
        int busy0, busy3, done0, done3;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        step(1'b0, 3'd3, 16'h0000, 3'd3, 3'd3, 1'b0);
        @(negedge clk);
        check("pre_write_a", rd_a[0], 16'h0000);
        check("pre_write_b", rd_b[1], 16'h0000);

        step(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b0);
        @(negedge clk);
        check("bypass_same_cycle", rd_a[0], 16'hBEEF);
        check("nobypass_same_cycle", rd_b[1], 16'h0000);

        step(1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b0);
        @(negedge clk);
        check("nobypass_next_cycle", rd_a[1], 16'hBEEF);
        check("bypass_next_cycle_b", rd_b[0], 16'hBEEF);

        step(1'b1, 3'd0, 16'h1234, 3'd0, 3'd1, 1'b0);
        step(1'b1, 3'd1, 16'h1234, 3'd0, 3'd1, 1'b0);
        step(1'b0, 3'd0, 16'h0000, 3'd0, 3'd1, 1'b0);
        @(negedge clk);
        check("zero_reg_entry0", rd_a[2], 16'h0000);
        check("zero_reg_entry1", rd_b[2], 16'h1234);
        check("plain_entry0", rd_a[0], 16'h1234);

        for (int k = 0; k < 8; k++) step(1'b1, 3'(k), 16'(16'h1111 * (k + 1)), 3'd0, 3'd0, 1'b0);
        step(1'b0, 3'd7, 16'h0000, 3'd6, 3'd7, 1'b0);
        @(negedge clk);
        check("d6_read6", rd_a[3], 16'h0000);
        check("d6_read7", rd_b[3], 16'h0000);
        check("fill_entry7", rd_b[0], 16'h8888);
        check("fill_entry6", rd_a[0], 16'h7777);

        // Sweep with a write pulse and a second clr while busy.
        step(1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b1);
        busy0 = 0; busy3 = 0; done0 = 0; done3 = 0;
        for (int j = 0; j < 12; j++) begin
            step(j == 2, 3'd5, 16'hFFFF, 3'(j), 3'(7 - j), j == 4);
            @(negedge clk);
            busy0 += int'(busy_o[0]); busy3 += int'(busy_o[3]);
            done0 += int'(done_o[0]); done3 += int'(done_o[3]);
        end
        check("busy_len_depth8", 16'(busy0), 16'd8);
        check("busy_len_depth6", 16'(busy3), 16'd6);
        check("done_pulses_depth8", 16'(done0), 16'd1);
        check("done_pulses_depth6", 16'(done3), 16'd1);
        step(1'b0, 3'd0, 16'h0000, 3'd5, 3'd7, 1'b0);
        @(negedge clk);
        check("entry5_after_sweep", rd_a[0], 16'h0000);

        // clr+we together, clr during busy, then clr on the done cycle.
        step(1'b1, 3'd2, 16'h2222, 3'd2, 3'd2, 1'b0);
        step(1'b1, 3'd2, 16'hAAAA, 3'd2, 3'd2, 1'b1);
        busy0 = 0;
        for (int j = 0; j < 12; j++) begin
            step(1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, (j == 1) || (j == 8));
            @(negedge clk);
            busy0 += int'(busy_o[0]);
        end
        check("busy_len_with_reclr", 16'(busy0), 16'd11);
        check("clr_we_dropped", rd_a[0], 16'h0000);
        for (int j = 0; j < 10; j++) step(1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 1'b0);
        @(negedge clk);
        check("sweeps_finished", 16'(busy_o[0]), 16'd0);

        // Reset in the middle of a sweep.
        step(1'b1, 3'd4, 16'h4444, 3'd4, 3'd4, 1'b0);
        step(1'b0, 3'd0, 16'h0000, 3'd4, 3'd4, 1'b1);
        step(1'b0, 3'd0, 16'h0000, 3'd4, 3'd4, 1'b0);
        step(1'b0, 3'd0, 16'h0000, 3'd4, 3'd4, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("reset_busy", 16'(busy_o[0]), 16'd0);
        check("reset_done", 16'(done_o[0]), 16'd0);
        check("reset_entry4", rd_a[0], 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;
        done0 = 0;
        for (int j = 0; j < 12; j++) begin
            step(1'b0, 3'd0, 16'h0000, 3'(j), 3'(7 - j), 1'b0);
            @(negedge clk);
            done0 += int'(done_o[0]);
        end
        check("no_done_after_reset", 16'(done0), 16'd0);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
